// File: rtl/montgomery_serial_if.sv
// Start/done multiply handshake between the exponentiation controller
// (master) and the bit-serial Montgomery multiplier (slave).
interface montgomery_serial_if #(
  parameter int unsigned WIDTH = 512
);
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (output start, in_a, in_b, in_m, input result, done);
  modport slave  (input start, in_a, in_b, in_m, output result, done);
endinterface

// File: rtl/montgomery_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One multiplicand bit per clock, then one cycle of conditional subtraction.
module montgomery_serial #(
  parameter int unsigned WIDTH = 512
) (
  input  logic               clk,
  input  logic               resetn,
  montgomery_serial_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOP, S_SUB, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH:0]   r_t;
  logic [CW-1:0]    r_count;
  logic             r_done;

  logic             w_ai;
  logic             w_q;
  logic             w_last;
  logic             w_ge;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_reduced;

  assign w_ai   = r_a_sh[0];
  assign w_q    = r_t[0] ^ (w_ai & r_b[0]);
  assign w_sum  = {1'b0, r_t}
                + (w_ai ? {2'b00, r_b} : '0)
                + (w_q  ? {2'b00, r_m} : '0);
  assign w_last = (r_count == CW'(WIDTH - 1));
  assign w_ge   = (r_t >= {1'b0, r_m});
  // T < 2M, so T-M fits in WIDTH bits and the low-WIDTH subtraction is exact
  assign w_reduced = w_ge ? (r_t[WIDTH-1:0] - r_m) : r_t[WIDTH-1:0];

  assign bus.result = r_result;
  assign bus.done   = r_done;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state decode: WIDTH loop iterations, one subtract, one done cycle
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOOP;
      S_LOOP:  if (w_last)    w_state_next = S_SUB;
      S_SUB:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add-reduce iterations, final result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_sh   <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.in_a;
            r_b     <= bus.in_b;
            r_m     <= bus.in_m;
            r_t     <= '0;
            r_count <= '0;
          end
        end
        S_LOOP: begin
          // q is chosen so the sum is even for odd M; the shift drops a zero
          assert (w_sum[0] == 1'b0);
          r_t     <= w_sum[WIDTH+1:1];
          r_a_sh  <= r_a_sh >> 1;
          r_count <= r_count + 1'b1;
        end
        S_SUB: begin
          r_result <= w_reduced;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_montgomery_serial.sv
// Scoreboard bench for montgomery_serial at WIDTH=8 (directed, M=239)
// and WIDTH=512 (random odd M against a division-based reference).
module tb_montgomery_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn8;
  logic rstn512;

  montgomery_serial_if #(.WIDTH(8))   bus8 ();
  montgomery_serial_if #(.WIDTH(512)) bus512 ();

  montgomery_serial #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .resetn (rstn8),
    .bus    (bus8)
  );

  montgomery_serial #(.WIDTH(512)) u_dut512 (
    .clk    (clk),
    .resetn (rstn512),
    .bus    (bus512)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]   q8_res[$];
  int unsigned  q8_cyc[$];
  logic [511:0] q512_res[$];
  int unsigned  q512_cyc[$];

  logic [7:0]   m8_exp;
  int unsigned  m8_cyc;
  logic [511:0] m512_exp;
  int unsigned  m512_cyc;

  // Monitor for the 8-bit instance: every done pulse must match the queue head
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      checks++;
      if (q8_res.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected cycle=%0d result=%0d", cyc, bus8.result);
      end else begin
        m8_exp = q8_res.pop_front();
        m8_cyc = q8_cyc.pop_front();
        if (bus8.result !== m8_exp) begin
          errors++;
          $display("FAIL result8 got=%0d expected=%0d", bus8.result, m8_exp);
        end
        checks++;
        if (cyc != m8_cyc) begin
          errors++;
          $display("FAIL latency8 done_at=%0d expected=%0d", cyc, m8_cyc);
        end
      end
    end
  end

  // Monitor for the 512-bit instance
  always @(negedge clk) begin
    if (bus512.done === 1'b1) begin
      checks++;
      if (q512_res.size() == 0) begin
        errors++;
        $display("FAIL done512_unexpected cycle=%0d", cyc);
      end else begin
        m512_exp = q512_res.pop_front();
        m512_cyc = q512_cyc.pop_front();
        if (bus512.result !== m512_exp) begin
          errors++;
          $display("FAIL result512 got=%h expected=%h", bus512.result, m512_exp);
        end
        checks++;
        if (cyc != m512_cyc) begin
          errors++;
          $display("FAIL latency512 done_at=%0d expected=%0d", cyc, m512_cyc);
        end
      end
    end
  end

  // Reference: reduce A*B mod M by division, then halve mod M WIDTH times
  function automatic logic [511:0] mont_ref(input logic [511:0] a, b, m);
    logic [1023:0] p;
    logic [512:0]  x;
    p = {512'b0, a} * {512'b0, b};
    x = 513'(p % {512'b0, m});
    for (int i = 0; i < 512; i++) begin
      if (x[0]) x = (x + {1'b0, m}) >> 1;
      else      x = x >> 1;
    end
    return x[511:0];
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int unsigned acc;
    @(negedge clk);
    bus8.in_a  = a;
    bus8.in_b  = b;
    bus8.in_m  = 8'd239;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus8.start = 1'b0;
    q8_res.push_back(e);
    q8_cyc.push_back(acc + 9);
  endtask

  task automatic drain8();
    for (int i = 0; i < 200 && q8_res.size() != 0; i++) @(negedge clk);
    if (q8_res.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain8_timeout pending=%0d required=0", q8_res.size());
      q8_res.delete();
      q8_cyc.delete();
    end
  endtask

  task automatic op512(input logic [511:0] a, input logic [511:0] b,
                       input logic [511:0] m, input logic [511:0] e);
    int unsigned acc;
    @(negedge clk);
    bus512.in_a  = a;
    bus512.in_b  = b;
    bus512.in_m  = m;
    bus512.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus512.start = 1'b0;
    q512_res.push_back(e);
    q512_cyc.push_back(acc + 513);
  endtask

  task automatic drain512();
    for (int i = 0; i < 1200 && q512_res.size() != 0; i++) @(negedge clk);
    if (q512_res.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain512_timeout pending=%0d required=0", q512_res.size());
      q512_res.delete();
      q512_cyc.delete();
    end
  endtask

  task automatic check8(input string name, input logic [7:0] res_e, input logic done_e);
    checks++;
    if (bus8.result !== res_e || bus8.done !== done_e) begin
      errors++;
      $display("FAIL %s result=%0d done=%b expected result=%0d done=%b",
               name, bus8.result, bus8.done, res_e, done_e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned  acc;
    logic [511:0] ra, rb, rm;

    rstn8 = 1'b0;
    rstn512 = 1'b0;
    bus8.start = 1'b0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.in_m = '0;
    bus512.start = 1'b0; bus512.in_a = '0; bus512.in_b = '0; bus512.in_m = '0;
    repeat (3) @(negedge clk);
    check8("reset8", 8'd0, 1'b0);
    checks++;
    if (bus512.result !== '0 || bus512.done !== 1'b0) begin
      errors++;
      $display("FAIL reset512 result=%h done=%b expected 0", bus512.result, bus512.done);
    end
    rstn8 = 1'b1;
    rstn512 = 1'b1;

    // Directed WIDTH=8, M=239
    op8(8'd17, 8'd5, 8'd5);       drain8();
    op8(8'd1, 8'd1, 8'd225);      drain8();
    repeat (3) @(negedge clk);
    check8("hold225", 8'd225, 1'b0);
    op8(8'd238, 8'd238, 8'd225);  drain8();
    op8(8'd0, 8'd123, 8'd0);      drain8();
    op8(8'd17, 8'd238, 8'd238);   drain8();

    // start held high: one result per 11 cycles; in_a change mid-op affects the next op only
    @(negedge clk);
    bus8.in_a = 8'd17;
    bus8.in_b = 8'd5;
    bus8.in_m = 8'd239;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    q8_res.push_back(8'd5);   q8_cyc.push_back(acc + 9);
    q8_res.push_back(8'd169); q8_cyc.push_back(acc + 20);
    q8_res.push_back(8'd169); q8_cyc.push_back(acc + 31);
    repeat (4) @(negedge clk);
    bus8.in_a = 8'd1;
    repeat (21) @(negedge clk);
    bus8.start = 1'b0;
    drain8();

    // Reset mid-loop: no done, result cleared
    @(negedge clk);
    bus8.in_a = 8'd17;
    bus8.in_b = 8'd5;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (5) @(negedge clk);
    rstn8 = 1'b0;
    #1;
    check8("midreset", 8'd0, 1'b0);
    @(negedge clk);
    rstn8 = 1'b1;
    repeat (15) @(negedge clk);
    check8("after_reset", 8'd0, 1'b0);

    // Controller-style restart: one-cycle reset pulse, start on the next edge
    @(negedge clk);
    rstn8 = 1'b0;
    @(negedge clk);
    rstn8 = 1'b1;
    bus8.in_a = 8'd1;
    bus8.in_b = 8'd1;
    bus8.in_m = 8'd239;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus8.start = 1'b0;
    q8_res.push_back(8'd225);
    q8_cyc.push_back(acc + 9);
    drain8();

    // WIDTH=512 with random odd moduli
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 16; w++) begin
        rm[w*32 +: 32] = $urandom;
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rm[0] = 1'b1;
      ra = ra % rm;
      rb = rb % rm;
      if (t == 0) op512('0, rb, rm, '0);
      else        op512(ra, rb, rm, mont_ref(ra, rb, rm));
      drain512();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
